// File: rtl/logic_sweep_ctrl_pkg.sv
// Shared types and defaults for the logic sweep sequencer.
// The three implementations are checked against each other for equivalence.
package logic_sweep_pkg;

  localparam int N_IN_DEF   = 2;
  localparam int N_OUT_DEF  = 3;
  localparam int SETTLE_DEF = 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } sweep_state_t;

  typedef logic [CNT_W-1:0] settle_cnt_t;

  // Counter reload: the counter runs SETTLE_CYCLES-1 down to 0, which gives SETTLE_CYCLES cycles.
  function automatic settle_cnt_t settle_reload(input int settle_cycles);
    return settle_cnt_t'(settle_cycles - 1);
  endfunction

endpackage

// File: rtl/logic_sweep_ctrl_if.sv
// Sweep bus. It carries the stimulus and the three output buses of the implementations,
// plus the control and result signals.
interface logic_sweep_ctrl_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 3
);
  logic              start;
  logic [N_IN-1:0]   in_vec;
  logic [N_OUT-1:0]  y_s;
  logic [N_OUT-1:0]  y_d;
  logic [N_OUT-1:0]  y_b;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     mismatch_cnt;
  logic              fail_valid;
  logic [N_IN-1:0]   fail_vec;
  logic [N_OUT-1:0]  fail_bits;

  modport master (
    output start, y_s, y_d, y_b,
    input  in_vec, busy, done, pass, mismatch_cnt, fail_valid, fail_vec, fail_bits
  );

  modport slave (
    input  start, y_s, y_d, y_b,
    output in_vec, busy, done, pass, mismatch_cnt, fail_valid, fail_vec, fail_bits
  );
endinterface

// File: rtl/logic_sweep_ctrl_compare.sv
// Three-way comparator. It produces a mask of output bits where any implementation disagrees.
module lsc_compare #(
  parameter int N_OUT = 3
) (
  input  logic [N_OUT-1:0] y_s_i,
  input  logic [N_OUT-1:0] y_d_i,
  input  logic [N_OUT-1:0] y_b_i,
  output logic [N_OUT-1:0] diff_o,
  output logic             any_mismatch_o
);

  for (genvar i = 0; i < N_OUT; i++) begin : g_bit
    assign diff_o[i] = (y_s_i[i] ^ y_d_i[i]) | (y_s_i[i] ^ y_b_i[i]);
  end

  // The case-inequality operator makes an X on any output count as a failure instead of being skipped.
  assign any_mismatch_o = (diff_o !== '0);

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Exhaustive input sweep across the three logic implementations. For each vector it waits a
// settle window, then compares the outputs and records the first failure.
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int N_OUT         = N_OUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  logic_sweep_ctrl_if.slave sw_if
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam settle_cnt_t     RELOAD   = settle_reload(SETTLE_CYCLES);

  sweep_state_t      state_q;
  settle_cnt_t       cnt_q;
  logic [N_IN-1:0]   vec_q;
  logic [N_IN-1:0]   fail_vec_q;
  logic [N_OUT-1:0]  fail_bits_q;
  logic [N_IN:0]     mcnt_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_valid_q;

  logic [N_OUT-1:0]  diff;
  logic              any_mm;

  lsc_compare #(.N_OUT(N_OUT)) u_cmp (
    .y_s_i          (sw_if.y_s),
    .y_d_i          (sw_if.y_d),
    .y_b_i          (sw_if.y_b),
    .diff_o         (diff),
    .any_mismatch_o (any_mm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      fail_vec_q   <= '0;
      fail_bits_q  <= '0;
      mcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sw_if.start) begin
            state_q      <= SETTLE;
            busy_q       <= 1'b1;
            vec_q        <= '0;
            cnt_q        <= RELOAD;
            mcnt_q       <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_bits_q  <= '0;
            pass_q       <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_q <= CHECK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        CHECK: begin
          if (any_mm) begin
            mcnt_q <= mcnt_q + 1'b1;
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= vec_q;
              fail_bits_q  <= diff;
            end
          end
          // done and busy are registered here so that they line up with the DONE state.
          if (vec_q == LAST_VEC) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= RELOAD;
            state_q <= SETTLE;
          end
        end
        DONE: begin
          pass_q  <= (mcnt_q == '0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_if.in_vec       = vec_q;
  assign sw_if.busy         = busy_q;
  assign sw_if.done         = done_q;
  assign sw_if.pass         = pass_q;
  assign sw_if.mismatch_cnt = mcnt_q;
  assign sw_if.fail_valid   = fail_valid_q;
  assign sw_if.fail_vec     = fail_vec_q;
  assign sw_if.fail_bits    = fail_bits_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Directed bench for logic_sweep_ctrl. The main DUT uses SETTLE_CYCLES=2 and has a selectable
// fault model. A second DUT uses SETTLE_CYCLES=1 and sees a late dataflow output.
module tb_logic_sweep_ctrl;

  localparam int NI = 2;
  localparam int NO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_sweep_ctrl_if #(.N_IN(NI), .N_OUT(NO)) bus2 ();
  logic_sweep_ctrl_if #(.N_IN(NI), .N_OUT(NO)) bus1 ();

  logic_sweep_ctrl #(.N_IN(NI), .N_OUT(NO), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sw_if(bus2.slave));
  logic_sweep_ctrl #(.N_IN(NI), .N_OUT(NO), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_if(bus1.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  // Reference implementation: y1 = a&b, y2 = a|b, y3 = a^b, with a = bit 0 and b = bit 1.
  function automatic logic [2:0] f(input logic [1:0] v);
    return {v[0] ^ v[1], v[0] | v[1], v[0] & v[1]};
  endfunction

  // Late dataflow path: two register stages behind in_vec.
  logic [2:0] d2a, d2b, d1a, d1b;
  always @(posedge clk) begin
    d2a <= f(bus2.in_vec);
    d2b <= d2a;
    d1a <= f(bus1.in_vec);
    d1b <= d1a;
  end

  logic [2:0] g2, g1;
  always_comb begin
    g2 = f(bus2.in_vec);
    bus2.y_s = g2;
    bus2.y_d = g2;
    bus2.y_b = g2;
    case (mode)
      1: if (bus2.in_vec == 2'd2) bus2.y_b = g2 ^ 3'b010;
      2: bus2.y_d = ~g2;
      3: bus2.y_d = d2b;
      default: ;
    endcase
  end

  always_comb begin
    g1 = f(bus1.in_vec);
    bus1.y_s = g1;
    bus1.y_d = d1b;
    bus1.y_b = g1;
  end

  task automatic pulse_start2();
    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
  endtask

  task automatic wait_done2(output int edges);
    edges = 0;
    while (bus2.done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({bus2.busy, bus2.done, bus2.pass, bus2.fail_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {bus2.busy, bus2.done, bus2.pass, bus2.fail_valid});
    end
    n_cmp++;
    if ({bus2.in_vec, bus2.mismatch_cnt, bus2.fail_vec, bus2.fail_bits} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 000",
               {bus2.in_vec, bus2.mismatch_cnt, bus2.fail_vec, bus2.fail_bits});
    end
  endtask

  task automatic test_identical();
    mode = 0;
    pulse_start2();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (bus2.in_vec !== 2'(k / 3) || bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_seq[%0d]: got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                 k, bus2.in_vec, bus2.busy, bus2.done, k / 3);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus2.done !== 1'b1 || bus2.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_timing: got done=%b busy=%b want done=1 busy=0", bus2.done, bus2.busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus2.pass, bus2.mismatch_cnt, bus2.fail_valid, bus2.done} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL identical_result: got pass=%b cnt=%0d fv=%b done=%b want 1 0 0 0",
               bus2.pass, bus2.mismatch_cnt, bus2.fail_valid, bus2.done);
    end
  endtask

  task automatic test_single_fail();
    int e;
    mode = 1;
    pulse_start2();
    wait_done2(e);
    n_cmp++;
    if (e !== 12) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want 12", e);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus2.pass, bus2.mismatch_cnt, bus2.fail_valid, bus2.fail_vec, bus2.fail_bits}
        !== {1'b0, 3'd1, 1'b1, 2'b10, 3'b010}) begin
      n_bad++;
      $display("FAIL single_result: got pass=%b cnt=%0d fv=%b vec=%b bits=%b want 0 1 1 10 010",
               bus2.pass, bus2.mismatch_cnt, bus2.fail_valid, bus2.fail_vec, bus2.fail_bits);
    end
  endtask

  task automatic test_all_fail();
    int e;
    mode = 2;
    pulse_start2();
    wait_done2(e);
    @(posedge clk); #1;
    n_cmp++;
    if ({bus2.pass, bus2.mismatch_cnt, bus2.fail_valid, bus2.fail_vec, bus2.fail_bits}
        !== {1'b0, 3'd4, 1'b1, 2'b00, 3'b111} || e !== 12) begin
      n_bad++;
      $display("FAIL all_fail_result: got pass=%b cnt=%0d fv=%b vec=%b bits=%b lat=%0d want 0 4 1 00 111 12",
               bus2.pass, bus2.mismatch_cnt, bus2.fail_valid, bus2.fail_vec, bus2.fail_bits, e);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    mode = 2;
    pulse_start2();
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (bus2.in_vec !== 2'd1 || bus2.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_position: got vec=%0d busy=%b want 1 1", bus2.in_vec, bus2.busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus2.busy, bus2.done, bus2.pass, bus2.fail_valid, bus2.in_vec,
         bus2.mismatch_cnt, bus2.fail_vec, bus2.fail_bits} !== 14'd0) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b vec=%0d cnt=%0d fv=%b want all zero",
               bus2.busy, bus2.in_vec, bus2.mismatch_cnt, bus2.fail_valid);
    end
    #1 rst_n = 1'b1;
    mode = 0;
    pulse_start2();
    wait_done2(e);
    @(posedge clk); #1;
    n_cmp++;
    if (bus2.pass !== 1'b1 || bus2.mismatch_cnt !== 3'd0 || e !== 12) begin
      n_bad++;
      $display("FAIL post_reset_sweep: got pass=%b cnt=%0d lat=%0d want 1 0 12",
               bus2.pass, bus2.mismatch_cnt, e);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    mode = 0;
    dones = 0;
    pulse_start2();
    repeat (4) @(posedge clk);
    pulse_start2();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 1 || bus2.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_start: got dones=%0d busy=%b want 1 0", dones, bus2.busy);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, low_run, e;
    bit counting;
    mode = 0;
    d1 = -1; d2 = -1; low_run = 0; counting = 0;
    @(posedge clk); #1 bus2.start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) begin
        if (d1 < 0) begin d1 = k; counting = 1; end
        else if (d2 < 0) d2 = k;
      end
      if (counting) begin
        if (bus2.busy === 1'b0) low_run++;
        else counting = 0;
      end
    end
    bus2.start = 1'b0;
    n_cmp++;
    if (d1 !== 13 || d2 - d1 !== 14) begin
      n_bad++;
      $display("FAIL b2b_period: got first=%0d period=%0d want 13 14", d1, d2 - d1);
    end
    n_cmp++;
    if (low_run !== 2) begin
      n_bad++;
      $display("FAIL b2b_busy_gap: got %0d want 2", low_run);
    end
    wait_done2(e);
    @(posedge clk); #1;
  endtask

  task automatic test_settle1();
    int e;
    @(posedge clk); #1 bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    e = 0;
    while (bus1.done !== 1'b1 && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    n_cmp++;
    if (e !== 8) begin
      n_bad++;
      $display("FAIL settle1_latency: got %0d want 8", e);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus1.pass, bus1.mismatch_cnt, bus1.fail_vec, bus1.fail_bits}
        !== {1'b0, 3'd2, 2'b01, 3'b110}) begin
      n_bad++;
      $display("FAIL settle1_result: got pass=%b cnt=%0d vec=%b bits=%b want 0 2 01 110",
               bus1.pass, bus1.mismatch_cnt, bus1.fail_vec, bus1.fail_bits);
    end
    mode = 3;
    pulse_start2();
    wait_done2(e);
    @(posedge clk); #1;
    n_cmp++;
    if (bus2.pass !== 1'b1 || bus2.mismatch_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL settle2_late_path: got pass=%b cnt=%0d want 1 0", bus2.pass, bus2.mismatch_cnt);
    end
    mode = 0;
  endtask

  initial begin
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    #1 rst_n = 1'b1;
    test_reset();
    test_identical();
    test_single_fail();
    test_all_fail();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_settle1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
